seq_div32_16: RTL and testbench
===============================

SEQ_DIV32_16 -- requirements
Module: seq_div32_16

Interface
REQ-001 The module SHALL have parameter DW, default 32, meaning dividend and quotient width.
REQ-002 The module SHALL have parameter VW, default 16, meaning divisor and remainder width; VW <= DW.
REQ-003 Port clk, input, 1, meaning the single clock; all state SHALL update on its rising edge.
REQ-004 Port rst, input, 1, meaning reset: asynchronous and active-high.
REQ-005 Port start, input, 1, meaning request a divide using the current dividend and divisor.
REQ-006 Port dividend, input, DW, meaning unsigned numerator, sampled only when start is accepted.
REQ-007 Port divisor, input, VW, meaning unsigned denominator, sampled only when start is accepted.
REQ-008 Port busy, output, 1, meaning a divide is in progress.
REQ-009 Port done, output, 1, meaning a one-cycle pulse: quotient and remainder are valid.
REQ-010 Port quotient, output, DW, meaning floor(dividend/divisor).
REQ-011 Port remainder, output, VW, meaning dividend mod divisor.
REQ-012 Port dbz, output, 1, meaning divide-by-zero flag; it SHALL be present only with SEQ_DIV_DBZ_EN.

Function
REQ-013 The block SHALL be a radix-2 restoring divider resolving one quotient bit per clock, MSB first.
REQ-014 The FSM SHALL have states IDLE, RUN and DONE, with RUN holding for exactly DW cycles.
REQ-015 start SHALL be accepted when busy==0 (IDLE or DONE); the accepting edge latches operands, clears the bit counter and enters RUN.
REQ-016 start SHALL be ignored while busy==1; operand changes during RUN SHALL have no effect.
REQ-017 Each RUN edge SHALL do the following: shift the next dividend bit into a VW+1-bit partial remainder; if partial >= divisor, subtract and set the quotient bit to 1, otherwise set it to 0.
REQ-018 The DW-th RUN edge SHALL write quotient and remainder, enter DONE, drive busy=0 and drive done=1.
REQ-019 done SHALL be high exactly DW cycles after the accepting edge, for one cycle only.
REQ-020 DONE SHALL go to IDLE on the next edge, or to RUN if start is high in that cycle.
REQ-021 quotient, remainder and dbz SHALL hold their values until the next completion.
REQ-022 busy SHALL be 1 in RUN and 0 otherwise.
REQ-023 divisor==0 without the macro SHALL give quotient = all ones and remainder = dividend[VW-1:0] after DW cycles.

Reset
REQ-024 rst SHALL immediately force IDLE, busy=0, done=0, quotient=0, remainder=0, dbz=0 and clear the counter.
REQ-025 Reset during RUN SHALL abort the operation, with no done pulse and no partial result visible.
REQ-026 The first start after rst deasserts SHALL be accepted normally.

Configuration
REQ-027 With SEQ_DIV_DBZ_EN defined, an accepted start with divisor==0 SHALL skip RUN and enter DONE on the accepting edge.
REQ-028 In that case done and dbz SHALL be 1 the following cycle, with quotient = all ones and remainder = dividend[VW-1:0].
REQ-029 With SEQ_DIV_DBZ_EN undefined, the dbz port and early exit SHALL be absent and REQ-023 SHALL apply.

Structure
REQ-030 Package seq_div_pkg SHALL hold the FSM state encoding (IDLE, RUN, DONE) and the default DW and VW constants.
REQ-031 A combinational sub-module, seq_div_step, SHALL perform one compare/subtract/shift iteration (VW+1-bit partial remainder in, next partial and quotient bit out).

Verification
REQ-032 dividend=225, divisor=15 -> quotient=15, remainder=0; done exactly 32 cycles after the accepting edge.
REQ-033 dividend=100, divisor=7 -> quotient=14, remainder=2; a second start in the done cycle (4294836225/65535) -> quotient=65535, remainder=0.
REQ-034 dividend=0xFFFFFFFF, divisor=1 -> quotient=0xFFFFFFFF, remainder=0; divisor=0xFFFF -> quotient=65537, remainder=0.
REQ-035 start pulsed again at cycle 10 of RUN with new operands -> ignored, first result unchanged, single done pulse.
REQ-036 rst asserted at cycle 20 of RUN -> busy=0, quotient=0, no done; a subsequent 90/9 -> quotient=10, remainder=0.
REQ-037 divisor=0, dividend=0x12345678 -> quotient=0xFFFFFFFF, remainder=0x5678; latency 1 with dbz=1 if the macro is defined, else latency 32.

Source files
------------

// File: rtl/seq_div_pkg.sv
// Shared definitions for the sequential radix-2 divider: FSM encoding and default widths.
package seq_div_pkg;

    localparam int DW_DEFAULT = 32;
    localparam int VW_DEFAULT = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/seq_div_step.sv
// One restoring-division iteration: shift the next dividend bit into the partial
// remainder, subtract the divisor when it fits, and report the quotient bit.
module seq_div_step
    import seq_div_pkg::*;
#(
    parameter int VW = VW_DEFAULT
) (
    input  logic [VW:0]   part_i,
    input  logic          bit_i,
    input  logic [VW-1:0] divisor_i,
    output logic [VW:0]   part_o,
    output logic          qbit_o
);

    localparam int PW = VW + 1;

    logic [VW+1:0] shifted;

    always_comb begin
        shifted = {part_i, bit_i};
        qbit_o  = (shifted >= {2'b00, divisor_i});
        // With a zero divisor the top bit falls off, leaving a sliding window of dividend bits
        part_o  = qbit_o ? PW'(shifted - {2'b00, divisor_i}) : shifted[VW:0];
    end

endmodule

// File: rtl/seq_div32_16.sv
// Sequential unsigned DW/VW divider, one quotient bit per clock, MSB first.
// Define SEQ_DIV_DBZ_EN to add the dbz flag and a one-cycle exit for a zero divisor.
module seq_div32_16
    import seq_div_pkg::*;
#(
    parameter int DW = DW_DEFAULT,
    parameter int VW = VW_DEFAULT
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [DW-1:0] dividend,
    input  logic [VW-1:0] divisor,
    output logic          busy,
    output logic          done,
    output logic [DW-1:0] quotient,
    output logic [VW-1:0] remainder
`ifdef SEQ_DIV_DBZ_EN
    ,
    output logic          dbz
`endif
);

    // state | meaning
    // IDLE  | waiting for start, last result held
    // RUN   | resolving one quotient bit per edge, DW edges total
    // DONE  | result valid, done high for this single cycle

    localparam int            CW       = (DW > 1) ? $clog2(DW) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DW - 1);

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [DW-1:0] work_q, work_d;
    logic [VW:0]   part_q, part_d, part_nxt;
    logic [VW-1:0] divr_q, divr_d;
    logic [DW-1:0] quot_q, quot_d;
    logic [VW-1:0] rem_q, rem_d;
    logic          qbit;
`ifdef SEQ_DIV_DBZ_EN
    logic          dbz_q, dbz_d;
`endif

    seq_div_step #(.VW(VW)) u_step (
        .part_i    (part_q),
        .bit_i     (work_q[DW-1]),
        .divisor_i (divr_q),
        .part_o    (part_nxt),
        .qbit_o    (qbit)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            work_q  <= '0;
            part_q  <= '0;
            divr_q  <= '0;
            quot_q  <= '0;
            rem_q   <= '0;
`ifdef SEQ_DIV_DBZ_EN
            dbz_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            work_q  <= work_d;
            part_q  <= part_d;
            divr_q  <= divr_d;
            quot_q  <= quot_d;
            rem_q   <= rem_d;
`ifdef SEQ_DIV_DBZ_EN
            dbz_q   <= dbz_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        work_d  = work_q;
        part_d  = part_q;
        divr_d  = divr_q;
        quot_d  = quot_q;
        rem_d   = rem_q;
`ifdef SEQ_DIV_DBZ_EN
        dbz_d   = dbz_q;
`endif
        case (state_q)
            IDLE, DONE: begin
                state_d = IDLE;
                if (start) begin
                    state_d = RUN;
                    cnt_d   = '0;
                    work_d  = dividend;
                    part_d  = '0;
                    divr_d  = divisor;
`ifdef SEQ_DIV_DBZ_EN
                    if (divisor == '0) begin
                        state_d = DONE;
                        quot_d  = '1;
                        rem_d   = dividend[VW-1:0];
                        dbz_d   = 1'b1;
                    end
`endif
                end
            end
            RUN: begin
                // Dividend bits leave at the top while quotient bits enter at the bottom
                work_d = {work_q[DW-2:0], qbit};
                part_d = part_nxt;
                cnt_d  = cnt_q + CW'(1);
                if (cnt_q == CNT_LAST) begin
                    state_d = DONE;
                    cnt_d   = '0;
                    quot_d  = {work_q[DW-2:0], qbit};
                    rem_d   = part_nxt[VW-1:0];
`ifdef SEQ_DIV_DBZ_EN
                    dbz_d   = 1'b0;
`endif
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign busy      = (state_q == RUN);
    assign done      = (state_q == DONE);
    assign quotient  = quot_q;
    assign remainder = rem_q;
`ifdef SEQ_DIV_DBZ_EN
    assign dbz       = dbz_q;
`endif

endmodule

// File: tb/tb_seq_div32_16.sv
// Self-checking bench for seq_div32_16: directed corner cases plus randomized divides
// compared against plain integer division.
module tb_seq_div32_16;

    localparam int DW  = 32;
    localparam int VW  = 16;
    localparam int TMO = 200;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [DW-1:0] dividend;
    logic [VW-1:0] divisor;
    logic          busy;
    logic          done;
    logic [DW-1:0] quotient;
    logic [VW-1:0] remainder;
`ifdef SEQ_DIV_DBZ_EN
    logic          dbz;
`endif

    int n_vec = 0;
    int n_bad = 0;

    seq_div32_16 #(.DW(DW), .VW(VW)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .dividend  (dividend),
        .divisor   (divisor),
        .busy      (busy),
        .done      (done),
        .quotient  (quotient),
        .remainder (remainder)
`ifdef SEQ_DIV_DBZ_EN
        ,
        .dbz       (dbz)
`endif
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: floor division, zero divisor gives all ones and the low dividend bits.
    // lat = clock edges after the accepting edge until done is visible.
    function automatic void model(input logic [DW-1:0] a, input logic [VW-1:0] b,
                                  output logic [DW-1:0] q, output logic [VW-1:0] r,
                                  output int lat);
        if (b == '0) begin
            q = '1;
            r = a[VW-1:0];
        end else begin
            q = a / DW'(b);
            r = VW'(a % DW'(b));
        end
`ifdef SEQ_DIV_DBZ_EN
        lat = (b == '0) ? 0 : DW;
`else
        lat = DW;
`endif
    endfunction

    // Issues one divide from the current (non-busy) cycle and waits for done.
    // Operands are scrambled right after acceptance; they must not be resampled.
    task automatic do_div(input logic [DW-1:0] a, input logic [VW-1:0] b,
                          output int lat, output logic [DW-1:0] q, output logic [VW-1:0] r,
                          output logic bsy, output logic z);
        start    = 1'b1;
        dividend = a;
        divisor  = b;
        tick();
        start    = 1'b0;
        dividend = $urandom;
        divisor  = VW'($urandom);
        bsy      = busy;
        lat      = 0;
        while (!done && lat < TMO) begin
            tick();
            lat++;
        end
        if (!done) lat = -1;
        q = quotient;
        r = remainder;
`ifdef SEQ_DIV_DBZ_EN
        z = dbz;
`else
        z = 1'b0;
`endif
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; dividend = '0; divisor = '0;
        repeat (3) tick();
        n_vec++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got=%0b want=0", busy); end
        n_vec++; if (done !== 1'b0) begin n_bad++; $display("FAIL reset_done got=%0b want=0", done); end
        n_vec++; if (quotient !== '0) begin n_bad++; $display("FAIL reset_quot got=%0h want=0", quotient); end
        n_vec++; if (remainder !== '0) begin n_bad++; $display("FAIL reset_rem got=%0h want=0", remainder); end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_basic();
        int lat, elat;
        logic [DW-1:0] q, eq;
        logic [VW-1:0] r, er;
        logic bsy, z;
        model(32'd225, 16'd15, eq, er, elat);
        do_div(32'd225, 16'd15, lat, q, r, bsy, z);
        n_vec++; if (q !== 32'd15) begin n_bad++; $display("FAIL basic_quot got=%0d want=15", q); end
        n_vec++; if (r !== 16'd0) begin n_bad++; $display("FAIL basic_rem got=%0d want=0", r); end
        n_vec++; if (lat !== 32) begin n_bad++; $display("FAIL basic_latency got=%0d want=32", lat); end
        n_vec++; if (bsy !== 1'b1) begin n_bad++; $display("FAIL basic_busy got=%0b want=1", bsy); end
        tick();
        n_vec++; if (done !== 1'b0) begin n_bad++; $display("FAIL done_one_cycle got=%0b want=0", done); end
        n_vec++; if (busy !== 1'b0) begin n_bad++; $display("FAIL idle_busy got=%0b want=0", busy); end
        repeat (3) tick();
        n_vec++; if (quotient !== eq) begin n_bad++; $display("FAIL hold_quot got=%0d want=%0d", quotient, eq); end
    endtask

    task automatic test_back_to_back();
        int lat;
        logic [DW-1:0] q;
        logic [VW-1:0] r;
        logic bsy, z;
        do_div(32'd100, 16'd7, lat, q, r, bsy, z);
        n_vec++; if (q !== 32'd14) begin n_bad++; $display("FAIL b2b_first_quot got=%0d want=14", q); end
        n_vec++; if (r !== 16'd2) begin n_bad++; $display("FAIL b2b_first_rem got=%0d want=2", r); end
        do_div(32'd4294836225, 16'd65535, lat, q, r, bsy, z);
        n_vec++; if (q !== 32'd65535) begin n_bad++; $display("FAIL b2b_second_quot got=%0d want=65535", q); end
        n_vec++; if (r !== 16'd0) begin n_bad++; $display("FAIL b2b_second_rem got=%0d want=0", r); end
        n_vec++; if (lat !== 32) begin n_bad++; $display("FAIL b2b_latency got=%0d want=32", lat); end
    endtask

    task automatic test_limits();
        int lat;
        logic [DW-1:0] q;
        logic [VW-1:0] r;
        logic bsy, z;
        tick();
        do_div(32'hFFFF_FFFF, 16'd1, lat, q, r, bsy, z);
        n_vec++; if (q !== 32'hFFFF_FFFF) begin n_bad++; $display("FAIL max_div1_quot got=%0h want=ffffffff", q); end
        n_vec++; if (r !== 16'd0) begin n_bad++; $display("FAIL max_div1_rem got=%0h want=0", r); end
        tick();
        do_div(32'hFFFF_FFFF, 16'hFFFF, lat, q, r, bsy, z);
        n_vec++; if (q !== 32'd65537) begin n_bad++; $display("FAIL max_divmax_quot got=%0d want=65537", q); end
        n_vec++; if (r !== 16'd0) begin n_bad++; $display("FAIL max_divmax_rem got=%0d want=0", r); end
    endtask

    task automatic test_ignore_start();
        int lat, ndone;
        logic [DW-1:0] q, eq;
        logic [VW-1:0] r, er;
        int elat;
        model(32'd1000000, 16'd1234, eq, er, elat);
        tick();
        start = 1'b1; dividend = 32'd1000000; divisor = 16'd1234;
        tick();
        start = 1'b0;
        ndone = 0; lat = -1; q = '0; r = '0;
        for (int cyc = 1; cyc <= 60; cyc++) begin
            if (cyc == 10) begin
                start = 1'b1; dividend = 32'h0BAD_F00D; divisor = 16'd3;
            end else begin
                start = 1'b0;
            end
            tick();
            if (done) begin
                ndone++;
                if (lat < 0) begin lat = cyc; q = quotient; r = remainder; end
            end
        end
        n_vec++; if (ndone !== 1) begin n_bad++; $display("FAIL ignore_done_count got=%0d want=1", ndone); end
        n_vec++; if (lat !== elat) begin n_bad++; $display("FAIL ignore_latency got=%0d want=%0d", lat, elat); end
        n_vec++; if (q !== eq) begin n_bad++; $display("FAIL ignore_quot got=%0d want=%0d", q, eq); end
        n_vec++; if (r !== er) begin n_bad++; $display("FAIL ignore_rem got=%0d want=%0d", r, er); end
    endtask

    task automatic test_reset_mid_run();
        int lat, nd;
        logic [DW-1:0] q;
        logic [VW-1:0] r;
        logic bsy, z;
        start = 1'b1; dividend = 32'd77777; divisor = 16'd13;
        tick();
        start = 1'b0;
        repeat (19) tick();
        #2 rst = 1'b1;
        #1;
        n_vec++; if (busy !== 1'b0) begin n_bad++; $display("FAIL midrst_busy got=%0b want=0", busy); end
        n_vec++; if (done !== 1'b0) begin n_bad++; $display("FAIL midrst_done got=%0b want=0", done); end
        n_vec++; if (quotient !== '0) begin n_bad++; $display("FAIL midrst_quot got=%0h want=0", quotient); end
        n_vec++; if (remainder !== '0) begin n_bad++; $display("FAIL midrst_rem got=%0h want=0", remainder); end
        @(posedge clk); #1;
        rst = 1'b0;
        nd = 0;
        repeat (40) begin
            tick();
            if (done) nd++;
        end
        n_vec++; if (nd !== 0) begin n_bad++; $display("FAIL midrst_no_done got=%0d want=0", nd); end
        do_div(32'd90, 16'd9, lat, q, r, bsy, z);
        n_vec++; if (q !== 32'd10) begin n_bad++; $display("FAIL after_rst_quot got=%0d want=10", q); end
        n_vec++; if (r !== 16'd0) begin n_bad++; $display("FAIL after_rst_rem got=%0d want=0", r); end
        n_vec++; if (lat !== 32) begin n_bad++; $display("FAIL after_rst_latency got=%0d want=32", lat); end
    endtask

    task automatic test_div_by_zero();
        int lat, elat;
        logic [DW-1:0] q, eq;
        logic [VW-1:0] r, er;
        logic bsy, z;
        model(32'h1234_5678, 16'd0, eq, er, elat);
        tick();
        do_div(32'h1234_5678, 16'd0, lat, q, r, bsy, z);
        n_vec++; if (q !== 32'hFFFF_FFFF) begin n_bad++; $display("FAIL dbz_quot got=%0h want=ffffffff", q); end
        n_vec++; if (r !== 16'h5678) begin n_bad++; $display("FAIL dbz_rem got=%0h want=5678", r); end
        n_vec++; if (lat !== elat) begin n_bad++; $display("FAIL dbz_latency got=%0d want=%0d", lat, elat); end
`ifdef SEQ_DIV_DBZ_EN
        n_vec++; if (z !== 1'b1) begin n_bad++; $display("FAIL dbz_flag got=%0b want=1", z); end
`endif
    endtask

    task automatic test_random();
        int lat, elat, gap, sel;
        logic [DW-1:0] a, q, eq, last_q;
        logic [VW-1:0] b, r, er;
        logic bsy, z;
        last_q = quotient;
        for (int i = 0; i < 24; i++) begin
            a   = $urandom;
            sel = $urandom_range(0, 7);
            if (sel == 0)      b = '0;
            else if (sel < 3)  b = VW'($urandom_range(1, 15));
            else if (sel == 3) b = 16'hFFFF;
            else               b = VW'($urandom);
            if ($urandom_range(0, 3) == 0) a = DW'($urandom_range(0, 70000));
            gap = $urandom_range(0, 2);
            repeat (gap) tick();
            if (gap > 0) begin
                n_vec++; if (quotient !== last_q) begin n_bad++; $display("FAIL rnd_hold[%0d] got=%0h want=%0h", i, quotient, last_q); end
            end
            model(a, b, eq, er, elat);
            do_div(a, b, lat, q, r, bsy, z);
            n_vec++; if (q !== eq) begin n_bad++; $display("FAIL rnd_quot[%0d] %0d/%0d got=%0d want=%0d", i, a, b, q, eq); end
            n_vec++; if (r !== er) begin n_bad++; $display("FAIL rnd_rem[%0d] %0d/%0d got=%0d want=%0d", i, a, b, r, er); end
            n_vec++; if (lat !== elat) begin n_bad++; $display("FAIL rnd_latency[%0d] got=%0d want=%0d", i, lat, elat); end
`ifdef SEQ_DIV_DBZ_EN
            n_vec++; if (z !== (b == '0)) begin n_bad++; $display("FAIL rnd_dbz[%0d] got=%0b want=%0b", i, z, (b == '0)); end
`endif
            last_q = eq;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_limits();
        test_ignore_start();
        test_reset_mid_run();
        test_div_by_zero();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
